// File: rtl/ts_pkt_framer.sv
// Byte-wide TS to 32-bit word bus framer: one header word with the program index,
// then the payload packed big-endian. Optional sync-byte check: TS_PKT_FRAMER_SYNC_CHK_EN.
module ts_pkt_framer #(
  parameter int U_DLY                  = 1,
  parameter int CHNNUM_BIT_WIDTH       = 4,
  parameter int PROG_PER_CHAN_BITWIDTH = 4,
  parameter int PKT_BYTES              = 188
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [7:0]                                         ts_i_byte,
  input  logic                                               ts_i_val,
  input  logic                                               ts_i_sop,
  input  logic [CHNNUM_BIT_WIDTH+PROG_PER_CHAN_BITWIDTH-1:0] prog_idx,
  output logic [31:0]                                        ts_o_data,
  output logic                                               ts_o_val,
  output logic                                               ts_o_sop,
  output logic                                               ts_o_eop,
  output logic [15:0]                                        err_cnt
);

  localparam int PW = CHNNUM_BIT_WIDTH + PROG_PER_CHAN_BITWIDTH;
  localparam int CW = $clog2(PKT_BYTES);

  // Packet length must pack into whole words; U_DLY only affects simulation.
  if ((PKT_BYTES % 4) != 0 || U_DLY < 0) begin : g_cfg_chk
    $error("ts_pkt_framer: PKT_BYTES must be a multiple of 4");
  end

  typedef enum logic [0:0] {ST_IDLE, ST_PAYLOAD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] byte_cnt, byte_cnt_nxt;
  logic [31:0]   word_buf, word_buf_nxt;
  logic [PW-1:0] prog_q, prog_nxt;
  logic          hdr_pend, hdr_pend_nxt;
  logic [31:0]   data_nxt, merged;
  logic          val_nxt, sop_nxt, eop_nxt;
  logic          err_evt, sync_ok, sop_ok;
  logic [1:0]    lane;

`ifdef TS_PKT_FRAMER_SYNC_CHK_EN
  assign sync_ok = (ts_i_byte == 8'h47);
`else
  assign sync_ok = 1'b1;
`endif

  assign sop_ok = ts_i_val & ts_i_sop & sync_ok;
  assign lane   = byte_cnt[1:0];
  // first byte of a word lands in [31:24]
  assign merged = word_buf | ({24'h0, ts_i_byte} << {~lane, 3'b000});

  function automatic logic [31:0] hdr_word(input logic [PW-1:0] p);
    hdr_word = '0;
    hdr_word[CHNNUM_BIT_WIDTH-1:0]         = p[PW-1 -: CHNNUM_BIT_WIDTH];
    hdr_word[PROG_PER_CHAN_BITWIDTH+3:4]   = p[PROG_PER_CHAN_BITWIDTH-1:0];
  endfunction

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    word_buf_nxt = word_buf;
    prog_nxt     = prog_q;
    hdr_pend_nxt = 1'b0;
    data_nxt     = '0;
    val_nxt      = 1'b0;
    sop_nxt      = 1'b0;
    eop_nxt      = 1'b0;
    err_evt      = 1'b0;

    // deferred header of a packet that truncated its predecessor
    if (hdr_pend) begin
      data_nxt = hdr_word(prog_q);
      val_nxt  = 1'b1;
      sop_nxt  = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (sop_ok) begin
          prog_nxt     = prog_idx;
          word_buf_nxt = {ts_i_byte, 24'h0};
          byte_cnt_nxt = CW'(1);
          state_nxt    = ST_PAYLOAD;
          data_nxt     = hdr_word(prog_idx);
          val_nxt      = 1'b1;
          sop_nxt      = 1'b1;
        end else if (ts_i_val) begin
          err_evt = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (sop_ok) begin
          // flush the partial word, restart on this sop byte
          data_nxt     = word_buf;
          val_nxt      = 1'b1;
          sop_nxt      = 1'b0;
          eop_nxt      = 1'b1;
          err_evt      = 1'b1;
          prog_nxt     = prog_idx;
          hdr_pend_nxt = 1'b1;
          word_buf_nxt = {ts_i_byte, 24'h0};
          byte_cnt_nxt = CW'(1);
        end else if (ts_i_val) begin
          if (lane == 2'd3) begin
            data_nxt     = merged;
            val_nxt      = 1'b1;
            sop_nxt      = 1'b0;
            word_buf_nxt = '0;
            if (byte_cnt == CW'(PKT_BYTES - 1)) begin
              eop_nxt      = 1'b1;
              byte_cnt_nxt = '0;
              state_nxt    = ST_IDLE;
            end else begin
              byte_cnt_nxt = byte_cnt + CW'(1);
            end
          end else begin
            word_buf_nxt = merged;
            byte_cnt_nxt = byte_cnt + CW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      word_buf  <= '0;
      prog_q    <= '0;
      hdr_pend  <= 1'b0;
      ts_o_data <= '0;
      ts_o_val  <= 1'b0;
      ts_o_sop  <= 1'b0;
      ts_o_eop  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      word_buf  <= word_buf_nxt;
      prog_q    <= prog_nxt;
      hdr_pend  <= hdr_pend_nxt;
      ts_o_data <= data_nxt;
      ts_o_val  <= val_nxt;
      ts_o_sop  <= sop_nxt;
      ts_o_eop  <= eop_nxt;
      if (err_evt && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ts_pkt_framer.sv
// Scoreboard bench for ts_pkt_framer: expected words queued with their due cycle.
module tb_ts_pkt_framer;
  localparam int PKT = 188;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ts_i_byte = '0;
  logic        ts_i_val = 1'b0;
  logic        ts_i_sop = 1'b0;
  logic [7:0]  prog_idx = '0;
  logic [31:0] ts_o_data;
  logic        ts_o_val, ts_o_sop, ts_o_eop;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  ts_pkt_framer dut (
    .clk(clk), .rst_n(rst_n),
    .ts_i_byte(ts_i_byte), .ts_i_val(ts_i_val), .ts_i_sop(ts_i_sop), .prog_idx(prog_idx),
    .ts_o_data(ts_o_data), .ts_o_val(ts_o_val), .ts_o_sop(ts_o_sop), .ts_o_eop(ts_o_eop),
    .err_cnt(err_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  prog;
    bit          gap;
    logic [31:0] hdr;
  } vec_t;

  exp_t        q[$];
  int          checks = 0, errors = 0, cyc = 0, exp_err = 0, idx = 0;
  logic [31:0] acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missing_word: got nothing, expected %h sop=%b eop=%b at cyc %0d",
               q[0].data, q[0].sop, q[0].eop, q[0].cyc);
      void'(q.pop_front());
    end
    checks++;
    if (ts_o_val) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h sop=%b eop=%b at cyc %0d, expected none",
                 ts_o_data, ts_o_sop, ts_o_eop, cyc);
      end else begin
        e = q.pop_front();
        if (ts_o_data !== e.data || ts_o_sop !== e.sop || ts_o_eop !== e.eop || cyc != e.cyc) begin
          errors++;
          $display("FAIL word: got %h sop=%b eop=%b cyc=%0d, expected %h sop=%b eop=%b cyc=%0d",
                   ts_o_data, ts_o_sop, ts_o_eop, cyc, e.data, e.sop, e.eop, e.cyc);
        end
      end
    end else if (ts_o_data !== 32'h0 || ts_o_sop !== 1'b0 || ts_o_eop !== 1'b0) begin
      errors++;
      $display("FAIL idle_zero: got data=%h sop=%b eop=%b, expected all 0", ts_o_data, ts_o_sop, ts_o_eop);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input logic v, input logic s, input logic [7:0] p);
    @(negedge clk);
    ts_i_byte = b; ts_i_val = v; ts_i_sop = s; prog_idx = p;
  endtask

  // val=0 cycles carry junk, including a possibly asserted sop
  task automatic idle();
    put(8'($urandom), 1'b0, 1'($urandom), 8'($urandom));
  endtask

  task automatic push(input logic [31:0] d, input logic s, input logic e, input int dly);
    exp_t x;
    x.data = d; x.sop = s; x.eop = e; x.cyc = cyc + dly;
    q.push_back(x);
  endtask

  task automatic sop_byte(input logic [7:0] b, input logic [7:0] p, input logic [31:0] hdr,
                          input bit trunc, input logic [31:0] flush);
    put(b, 1'b1, 1'b1, p);
    if (trunc) begin
      push(flush, 1'b0, 1'b1, 1);
      push(hdr, 1'b1, 1'b0, 2);
      exp_err++;
    end else begin
      push(hdr, 1'b1, 1'b0, 1);
    end
    idx = 1;
    acc = {b, 24'h0};
  endtask

  task automatic data_byte(input logic [7:0] b, input bit gap);
    if (gap) idle();
    put(b, 1'b1, 1'b0, 8'($urandom));
    acc = acc | ({b, 24'h0} >> (8 * (idx % 4)));
    idx++;
    if (idx % 4 == 0) begin
      push(acc, 1'b0, idx == PKT, 1);
      acc = '0;
    end
    if (idx == PKT) idx = 0;
  endtask

  task automatic send_pkt(input logic [7:0] p, input logic [31:0] hdr, input bit gap);
    sop_byte(8'h47, p, hdr, 1'b0, 32'h0);
    for (int i = 1; i < PKT; i++) data_byte(8'(i), gap);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'h5A, 1'b0, 32'h000000A5};
    tbl[1] = '{8'h5A, 1'b1, 32'h000000A5};
    tbl[2] = '{8'h13, 1'b0, 32'h00000031};
    tbl[3] = '{8'hFF, 1'b1, 32'h000000FF};
    tbl[4] = '{8'h80, 1'b0, 32'h00000008};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_val", {31'h0, ts_o_val}, 32'h0);
    chk("rst_data", ts_o_data, 32'h0);
    chk("rst_err", {16'h0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    idle();

    // table of full packets, contiguous and gapped
    for (int i = 0; i < 5; i++) begin
      send_pkt(tbl[i].prog, tbl[i].hdr, tbl[i].gap);
      repeat (3) idle();
      chk("pkt_err", {16'h0, err_cnt}, 32'(exp_err));
    end

    // truncation after 6 bytes, flush holds the two pending bytes
    sop_byte(8'h47, 8'h5A, 32'h000000A5, 1'b0, 32'h0);
    data_byte(8'h01, 1'b0); data_byte(8'h02, 1'b0); data_byte(8'h03, 1'b0);
    data_byte(8'hAA, 1'b0); data_byte(8'hBB, 1'b0);
    sop_byte(8'h47, 8'h13, 32'h00000031, 1'b1, 32'hAABB0000);
    for (int i = 1; i < PKT; i++) data_byte(8'(i), 1'b0);
    repeat (3) idle();
    chk("trunc_err", {16'h0, err_cnt}, 32'h1);

    // orphan bytes in idle
    repeat (3) put(8'h11, 1'b1, 1'b0, 8'h00);
    exp_err += 3;
    idle();
    chk("orphan_err", {16'h0, err_cnt}, 32'(exp_err));

    // saturation
    repeat (65540) put(8'h22, 1'b1, 1'b0, 8'h00);
    idle(); idle();
    chk("sat_err", {16'h0, err_cnt}, 32'h0000FFFF);

    // reset while the 25th payload word is on the bus
    sop_byte(8'h47, 8'h22, 32'h00000022, 1'b0, 32'h0);
    for (int i = 1; i < 100; i++) data_byte(8'(i), 1'b0);
    @(negedge clk);
    ts_i_val = 1'b0; ts_i_sop = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_val", {31'h0, ts_o_val}, 32'h0);
    chk("rst_mid_eop", {31'h0, ts_o_eop}, 32'h0);
    chk("rst_mid_data", ts_o_data, 32'h0);
    chk("rst_mid_err", {16'h0, err_cnt}, 32'h0);
    chk("rst_mid_queue", 32'(q.size()), 32'h0);
    q.delete();
    exp_err = 0; idx = 0; acc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();
    send_pkt(8'h5A, 32'h000000A5, 1'b0);
    repeat (3) idle();
    chk("post_rst_err", {16'h0, err_cnt}, 32'h0);

`ifdef TS_PKT_FRAMER_SYNC_CHK_EN
    put(8'h00, 1'b1, 1'b1, 8'h21);
    exp_err++;
    repeat (3) idle();
    chk("sync_bad_err", {16'h0, err_cnt}, 32'(exp_err));
    send_pkt(8'h21, 32'h00000012, 1'b0);
`else
    sop_byte(8'h00, 8'h21, 32'h00000012, 1'b0, 32'h0);
    for (int i = 1; i < PKT; i++) data_byte(8'(i), 1'b0);
`endif
    repeat (3) idle();
    chk("final_err", {16'h0, err_cnt}, 32'(exp_err));
    chk("final_queue", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
